mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 81 ++++++++
 tb/tb_mem_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port RAM access controller with read/write requests and a full clear sweep
module mem_ctrl #(
    parameter logic [7:0] CLR_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       clr_start,
    output logic       clr_done,
    output logic       busy,
    output logic       ram_read,
    output logic       ram_write,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data,
    input  logic [7:0] ram_out
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, CLEAR} state_t;
    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_cnt;
    logic       w_accept;
    logic       w_last;
    // clr_start pre-empts acceptance so a pending request waits out the sweep
    assign req_ready = (r_state == IDLE) && !clr_start;
    assign w_accept  = req_valid && req_ready;
    assign busy      = r_state != IDLE;
    assign w_last    = r_cnt == 8'hFF;
    // state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    // next-state logic
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = clr_start ? CLEAR : w_accept ? (req_write ? WR : RD) : IDLE;
            RD:      w_next = RD_CAP;
            CLEAR:   w_next = w_last ? IDLE : CLEAR;
            default: w_next = IDLE;
        endcase
    end
    // memory strobes and buses decoded purely from registered state and latches
    always_comb begin
        ram_read    = r_state == RD;
        ram_write   = (r_state == WR) || (r_state == CLEAR);
        ram_address = (r_state == WR || r_state == RD) ? r_addr : (r_state == CLEAR) ? r_cnt : 8'h00;
        ram_data    = (r_state == WR) ? r_wdata : (r_state == CLEAR) ? CLR_VALUE : 8'h00;
    end
    // request latches and sweep counter (counter rests at 0 outside CLEAR)
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_cnt   <= 8'h00;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            r_cnt <= (r_state == CLEAR) ? r_cnt + 8'h01 : 8'h00;
        end
    // read response capture and completion pulses
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            clr_done  <= 1'b0;
        end else begin
            rsp_valid <= r_state == RD_CAP;
            if (r_state == RD_CAP) rsp_data <= ram_out;
            clr_done  <= (r_state == CLEAR) && w_last;
        end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl against a behavioural RAM
module tb_mem_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       clr_start = 1'b0;
    logic       clr_done;
    logic       busy;
    logic       ram_read;
    logic       ram_write;
    logic [7:0] ram_address;
    logic [7:0] ram_data;
    logic [7:0] ram_out = 8'h00;
    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_val = 8'h00;
    int         errors = 0;
    int         checks = 0;
    int         overlap = 0;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_address(ram_address), .ram_data(ram_data), .ram_out(ram_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (pl_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= pl_val;
        end else begin
            if (ram_write) mem[ram_address] <= ram_data;
            if (ram_read) ram_out <= mem[ram_address];
        end

    always @(negedge clk)
        if (rst && ram_read && ram_write) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        #1 check("wr_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("wr_strobe", ram_write, 1);
        check("wr_addr", ram_address, a);
        check("wr_data", ram_data, d);
        @(negedge clk);
        check("wr_one_cycle", ram_write, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        #1 check("rd_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("rd_strobe", ram_read, 1);
        check("rd_addr", ram_address, a);
        @(negedge clk);
        check("rd_cap_no_rsp", rsp_valid, 0);
        check("rd_cap_ready", req_ready, 0);
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, exp);
        @(negedge clk);
        check("rd_rsp_pulse", rsp_valid, 0);
        check("rd_rsp_hold", rsp_data, exp);
    endtask

    initial begin
        int bad;
        bit found;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ram_write", ram_write, 0);
        check("rst_ram_read", ram_read, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_clr_done", clr_done, 0);
        check("rst_req_ready", req_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        do_write(8'h3C, 8'hA5);
        do_read(8'h3C, 8'hA5);

        do_write(8'h00, 8'h11);
        do_write(8'hFF, 8'h11);
        clr_start = 1'b1;
        #1 check("clr_ready_low", req_ready, 0);
        @(negedge clk);
        clr_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!(ram_write && ram_address == 8'(i) && ram_data == 8'h00 && busy && !clr_done)) bad++;
            @(negedge clk);
        end
        check("clr_sweep_bad_cycles", bad, 0);
        check("clr_done_pulse", clr_done, 1);
        check("clr_busy_end", busy, 0);
        check("clr_write_end", ram_write, 0);
        @(negedge clk);
        check("clr_done_one_cycle", clr_done, 0);
        do_read(8'h00, 8'h00);
        do_read(8'hFF, 8'h00);

        do_write(8'h05, 8'h77);
        clr_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
        #1 check("prio_ready_low", req_ready, 0);
        @(negedge clk);
        clr_start = 1'b0;
        check("prio_busy", busy, 1);
        check("prio_no_read", ram_read, 0);
        found = 1'b0;
        for (int n = 0; n < 300 && !found; n++) begin
            if (clr_done) found = 1'b1;
            else @(negedge clk);
        end
        check("prio_clr_done_seen", found, 1);
        check("prio_ready_at_done", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("prio_rd_strobe", ram_read, 1);
        check("prio_rd_addr", ram_address, 8'h05);
        @(negedge clk);
        @(negedge clk);
        check("prio_rsp_valid", rsp_valid, 1);
        check("prio_rsp_data", rsp_data, 8'h00);

        pl_val = 8'h5A; pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (100) @(negedge clk);
        check("abort_addr_100", ram_address, 100);
        check("abort_write_before", ram_write, 1);
        rst = 1'b0;
        #1;
        check("abort_write", ram_write, 0);
        check("abort_read", ram_read, 0);
        check("abort_busy", busy, 0);
        check("abort_addr", ram_address, 0);
        check("abort_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (clr_done || busy || ram_write) bad++;
            @(negedge clk);
        end
        check("abort_no_resume", bad, 0);
        check("abort_ready_after", req_ready, 1);
        check("abort_mem_99", mem[99], 8'h00);
        check("abort_mem_100", mem[100], 8'h5A);
        check("abort_mem_255", mem[255], 8'h5A);

        do_write(8'h01, 8'h10);
        do_write(8'h02, 8'h20);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h01;
        #1 check("b2b_ready0", req_ready, 1);
        @(negedge clk);
        req_addr = 8'h02;
        check("b2b_rd1_addr", ram_address, 8'h01);
        check("b2b_ready_rd", req_ready, 0);
        @(negedge clk);
        check("b2b_ready_cap", req_ready, 0);
        @(negedge clk);
        check("b2b_rsp1_valid", rsp_valid, 1);
        check("b2b_rsp1_data", rsp_data, 8'h10);
        check("b2b_ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_rd2_strobe", ram_read, 1);
        check("b2b_rd2_addr", ram_address, 8'h02);
        @(negedge clk);
        check("b2b_gap", rsp_valid, 0);
        @(negedge clk);
        check("b2b_rsp2_valid", rsp_valid, 1);
        check("b2b_rsp2_data", rsp_data, 8'h20);

        check("no_read_write_overlap", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
